mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares one multi-cycle memory between the instruction-fetch port (port 0, read-only) and the data port (port 1, read/write) of the MIPS core.
- Arbitrates round-robin, issues a one-cycle enable to the memory, and waits for its completion pulse.
- Returns read data with a one-cycle ack to the owning port; a watchdog aborts accesses that never complete.
- Sits between the core's fetch/MEM stages and the memory controller.

Parameters:
AW, 32, address width
DW, 32, data width
TIMEOUT, 16, max WAIT cycles before abort; 1 <= TIMEOUT <= 2^CW-1
CW, 8, watchdog counter width

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  synchronous, active-high
i_req  in  1  fetch request, held until i_ack
i_addr  in  AW  fetch address, stable while i_req
i_rdata  out  DW  fetch read data
i_ack  out  1  fetch completion pulse
i_err  out  1  fetch timeout flag, valid with i_ack
d_req  in  1  data request, held until d_ack
d_we  in  1  1=write, 0=read, stable while d_req
d_addr  in  AW  data address
d_wdata  in  DW  write data
d_rdata  out  DW  data read data
d_ack  out  1  data completion pulse
d_err  out  1  data timeout flag, valid with d_ack
mem_en  out  1  one-cycle access strobe to memory
mem_we  out  1  write enable to memory
mem_addr  out  AW  memory address
mem_wdata  out  DW  memory write data
mem_rdata  in  DW  memory read data, valid when mem_done=1
mem_done  in  1  one-cycle completion pulse from memory
busy  out  1  1 in any state except IDLE
grant  out  1  current/last owner: 0=fetch, 1=data

Behaviour:
- Reset (synchronous, takes effect at the next clk edge, including mid-access):
  - Arbiter enters IDLE; the in-flight access is dropped with no ack.
  - All outputs go to 0: i_rdata, d_rdata, acks, errs, mem_*, busy, grant.
  - Watchdog counter = 0; last_grant = 1, so port 0 wins the first tie.
- IDLE:
  - Neither req high -> stay.
  - Exactly one req high -> grant it.
  - Both high -> grant the port != last_grant.
  - On grant:
    - Latch owner into grant/last_grant.
    - Latch mem_addr from i_addr or d_addr.
    - Latch mem_we (d_we for port 1, 0 for port 0) and mem_wdata (d_wdata for port 1, 0 for port 0).
    - Go to ISSUE.
- ISSUE: mem_en=1 for exactly this cycle; counter cleared; -> WAIT.
- WAIT:
  - mem_done=1 -> capture mem_rdata into the owner's rdata register (writes capture nothing; rdata unchanged); err=0; -> RESP.
  - Else if counter == TIMEOUT-1 -> owner's rdata = 0, err=1; -> RESP.
  - Else counter++.
  - mem_done and timeout in the same cycle: mem_done wins.
- RESP: owner's ack=1 for exactly this cycle, err valid alongside; -> IDLE.
- mem_done outside WAIT is ignored.
- mem_addr, mem_we and mem_wdata hold stable from ISSUE through RESP, and retain their values in IDLE until the next grant.
- i_rdata/d_rdata hold until that port's next ack. err is 0 whenever ack is 0.
- Latency: req seen in IDLE at cycle T -> mem_en at T+1 -> earliest ack at T+3 (mem_done at T+2).
  - Timeout ack arrives at T+2+TIMEOUT.
- Back-to-back: a requester drops or re-presents req at the edge ending RESP; IDLE evaluates the new value.
  - A continuously held req from both ports alternates owners every transaction.
- No requester is starved: with both requesting, grants strictly alternate.

Test Plan:
- Single fetch: i_req=1, i_addr=0x100; memory pulses mem_done 2 cycles after mem_en with mem_rdata=0xDEADBEEF -> mem_en 1 cycle, mem_we=0, mem_addr=0x100; i_ack one cycle with i_rdata=0xDEADBEEF, i_err=0; d_ack never asserts.
- Data write: d_req=1, d_we=1, d_addr=0x200, d_wdata=0x12345678; mem_done after 1 cycle -> mem_we=1, mem_wdata=0x12345678; d_ack at T+3; d_rdata unchanged.
- Contention: i_req and d_req both held from reset, mem_done immediate -> grant sequence 0,1,0,1; one ack per port per pair; i_ack and d_ack never in the same cycle.
- Timeout: TIMEOUT=4, d_req read, mem_done never asserts -> d_ack with d_err=1 and d_rdata=0 exactly 4 cycles after ISSUE+1; arbiter returns to IDLE.
- Done on the timeout cycle: mem_done at WAIT cycle TIMEOUT-1 with data 0xA5A5A5A5 -> err=0, rdata=0xA5A5A5A5.
- Reset mid-WAIT: assert reset for 1 cycle during WAIT -> next cycle busy=0, mem_en=0, no ack ever for the aborted request; a late mem_done is ignored; the next request is served normally, with fetch winning a tie.

Source files
------------

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Purpose  : Round-robin arbiter sharing one multi-cycle memory between the
//            instruction-fetch port (port 0, read-only) and the data port
//            (port 1, read/write), with a watchdog that aborts accesses the
//            memory never completes.
// Revision : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 16,
  parameter int CW      = 8
) (
  input  logic          clk,
  input  logic          reset,
  // fetch port (port 0)
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic [DW-1:0] i_rdata,
  output logic          i_ack,
  output logic          i_err,
  // data port (port 1)
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic [DW-1:0] d_rdata,
  output logic          d_ack,
  output logic          d_err,
  // memory side
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_done,
  // status
  output logic          busy,
  output logic          grant
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic          last_grant;   // owner of the previous grant; loser of the next tie
  logic [CW-1:0] wd_cnt;       // watchdog: WAIT cycles already spent
  logic          err_q;        // outcome of the current access, shown with ack
  logic          take;         // a grant happens at this edge
  logic          take_port;    // which port is granted when take=1
  logic          timed_out;

  assign timed_out = (wd_cnt == CW'(TIMEOUT - 1));

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next-state, arbitration decision and per-state strobes
  always_comb begin
    state_nxt = state;
    take      = 1'b0;
    take_port = 1'b0;
    mem_en    = 1'b0;
    busy      = 1'b1;
    i_ack     = 1'b0;
    d_ack     = 1'b0;
    i_err     = 1'b0;
    d_err     = 1'b0;
    case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (i_req || d_req) begin
          take = 1'b1;
          // On a tie the port that did not win last time goes next.
          take_port = (i_req && d_req) ? ~last_grant : d_req;
          state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: begin
        mem_en    = 1'b1;
        state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (mem_done || timed_out) state_nxt = S_RESP;
      end
      S_RESP: begin
        i_ack     = ~grant;
        d_ack     = grant;
        i_err     = ~grant & err_q;
        d_err     = grant & err_q;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Grant latch, memory request registers, watchdog and read-data capture
  always_ff @(posedge clk) begin
    if (reset) begin
      grant      <= 1'b0;
      last_grant <= 1'b1;
      mem_addr   <= '0;
      mem_we     <= 1'b0;
      mem_wdata  <= '0;
      i_rdata    <= '0;
      d_rdata    <= '0;
      err_q      <= 1'b0;
      wd_cnt     <= '0;
    end else begin
      if (take) begin
        grant      <= take_port;
        last_grant <= take_port;
        mem_addr   <= take_port ? d_addr : i_addr;
        mem_we     <= take_port & d_we;
        mem_wdata  <= take_port ? d_wdata : '0;
      end
      if (state == S_ISSUE) wd_cnt <= '0;
      if (state == S_WAIT) begin
        // A completion arriving on the last allowed cycle beats the watchdog.
        if (mem_done) begin
          err_q <= 1'b0;
          if (!mem_we) begin
            if (grant) d_rdata <= mem_rdata;
            else       i_rdata <= mem_rdata;
          end
        end else if (timed_out) begin
          err_q <= 1'b1;
          if (grant) d_rdata <= '0;
          else       i_rdata <= '0;
        end else begin
          wd_cnt <= wd_cnt + CW'(1);
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_arbiter
// Purpose  : Self-checking bench for mem_arbiter. A transaction-level model
//            schedules each access by cycle number (issue, completion, ack)
//            and every cycle the DUT outputs are compared against it.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

  localparam int AW      = 32;
  localparam int DW      = 32;
  localparam int TO      = 4;
  localparam int CW      = 8;
  localparam int NCYC    = 3000;
  localparam int DIR_END = 38;

  logic          clk = 1'b0;
  logic          reset;
  logic          i_req, d_req, d_we, mem_done;
  logic [AW-1:0] i_addr, d_addr;
  logic [DW-1:0] d_wdata, mem_rdata;
  logic [DW-1:0] i_rdata, d_rdata, mem_wdata;
  logic [AW-1:0] mem_addr;
  logic          i_ack, i_err, d_ack, d_err, mem_en, mem_we, busy, grant;

  always #5 clk = ~clk;

  mem_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TO), .CW(CW)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ack(i_ack), .i_err(i_err),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ack(d_ack), .d_err(d_err),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_done(mem_done),
    .busy(busy), .grant(grant)
  );

  int checks = 0;
  int passed = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Transaction-level model: one access at a time, timed by absolute cycle
  bit          m_active, m_owner, m_last, m_grant, m_to, m_we;
  int          t_issue, t_ack, force_d, d;
  logic [31:0] m_data, m_addr, m_wdata, m_irdata, m_drdata, dir_data;
  bit          e_ack, acked0, acked1, own;

  task automatic model_reset();
    m_active = 1'b0; m_last = 1'b1; m_grant = 1'b0; m_to = 1'b0; m_we = 1'b0;
    m_addr = '0; m_wdata = '0; m_irdata = '0; m_drdata = '0;
    t_issue = -10; t_ack = -10;
  endtask

  initial begin
    reset = 1'b1; i_req = 1'b0; d_req = 1'b0; d_we = 1'b0; mem_done = 1'b0;
    i_addr = '0; d_addr = '0; d_wdata = '0; mem_rdata = '0;
    force_d = -1; dir_data = '0; m_data = '0; m_owner = 1'b0;
    model_reset();

    for (int k = 0; k < NCYC; k++) begin
      @(negedge clk);
      // ---- compare outputs of cycle k against the model ----
      e_ack = m_active && (k == t_ack);
      chk("busy",      busy,      m_active);
      chk("grant",     grant,     m_grant);
      chk("mem_en",    mem_en,    m_active && (k == t_issue));
      chk("mem_we",    mem_we,    m_we);
      chk("mem_addr",  mem_addr,  m_addr);
      chk("mem_wdata", mem_wdata, m_wdata);
      chk("i_ack",     i_ack,     e_ack && !m_owner);
      chk("i_err",     i_err,     e_ack && !m_owner && m_to);
      chk("d_ack",     d_ack,     e_ack && m_owner);
      chk("d_err",     d_err,     e_ack && m_owner && m_to);
      chk("i_rdata",   i_rdata,   m_irdata);
      chk("d_rdata",   d_rdata,   m_drdata);

      // ---- hand-computed expectations for the directed opening ----
      case (k)
        0:  chk("pin_reset_busy", busy, 1'b0);
        3:  begin chk("pin_fetch_en", mem_en, 1'b1); chk("pin_fetch_addr", mem_addr, 32'h100);
                  chk("pin_fetch_we", mem_we, 1'b0); end
        6:  begin chk("pin_fetch_ack", i_ack, 1'b1); chk("pin_fetch_data", i_rdata, 32'hDEADBEEF);
                  chk("pin_fetch_err", i_err, 1'b0); end
        9:  begin chk("pin_wr_we", mem_we, 1'b1); chk("pin_wr_wdata", mem_wdata, 32'h12345678); end
        11: begin chk("pin_wr_ack", d_ack, 1'b1); chk("pin_wr_rdata", d_rdata, 32'h0); end
        19: begin chk("pin_edge_ack", d_ack, 1'b1); chk("pin_edge_err", d_err, 1'b0);
                  chk("pin_edge_data", d_rdata, 32'hA5A5A5A5); end
        27: begin chk("pin_to_ack", d_ack, 1'b1); chk("pin_to_err", d_err, 1'b1);
                  chk("pin_to_data", d_rdata, 32'h0); end
        28: chk("pin_to_idle", busy, 1'b0);
        34: begin chk("pin_rst_busy", busy, 1'b0); chk("pin_rst_en", mem_en, 1'b0); end
        36: begin chk("pin_tie_grant", grant, 1'b0); chk("pin_tie_addr", mem_addr, 32'h500); end
        38: begin chk("pin_tie_ack", i_ack, 1'b1); chk("pin_tie_data", i_rdata, 32'h0BADF00D); end
        default: ;
      endcase

      // ---- stimulus for the edge ending cycle k ----
      acked0 = e_ack && !m_owner;
      acked1 = e_ack && m_owner;
      if (k < DIR_END) begin
        case (k)
          1:  reset = 1'b0;
          2:  begin i_req = 1'b1; i_addr = 32'h100; force_d = 1; dir_data = 32'hDEADBEEF; end
          6:  i_req = 1'b0;
          8:  begin d_req = 1'b1; d_we = 1'b1; d_addr = 32'h200; d_wdata = 32'h12345678; force_d = 0; end
          11: d_req = 1'b0;
          13: begin d_req = 1'b1; d_we = 1'b0; d_addr = 32'h300; force_d = TO - 1; dir_data = 32'hA5A5A5A5; end
          19: d_req = 1'b0;
          21: begin d_req = 1'b1; d_addr = 32'h304; force_d = TO; end
          27: d_req = 1'b0;
          30: begin d_req = 1'b1; d_addr = 32'h400; force_d = TO; end
          33: begin reset = 1'b1; d_req = 1'b0; end
          34: reset = 1'b0;
          35: begin i_req = 1'b1; i_addr = 32'h500; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h600;
                    force_d = 0; dir_data = 32'h0BADF00D; end
          default: ;
        endcase
      end else begin
        reset = ($urandom % 150) == 0;
        if (!i_req || acked0) begin
          i_req  = ($urandom % 4) != 0;
          i_addr = $urandom;
        end
        if (!d_req || acked1) begin
          d_req   = ($urandom % 4) != 0;
          d_we    = $urandom % 2;
          d_addr  = $urandom;
          d_wdata = $urandom;
        end
      end

      // ---- memory responder ----
      if (m_active && !m_to && (k == t_ack - 1)) begin
        mem_done = 1'b1; mem_rdata = m_data;
      end else if (k == 34) begin
        mem_done = 1'b1; mem_rdata = 32'hFFFFFFFF;   // late completion after reset
      end else if (k >= DIR_END && (!m_active || k == t_issue || k == t_ack) && ($urandom % 6) == 0) begin
        mem_done = 1'b1; mem_rdata = $urandom;       // stray pulse outside WAIT
      end else begin
        mem_done = 1'b0; mem_rdata = $urandom;
      end

      // ---- advance the model to cycle k+1 ----
      if (reset) begin
        model_reset();
      end else if (!m_active) begin
        if (i_req || d_req) begin
          own      = (i_req && d_req) ? !m_last : d_req;
          m_active = 1'b1; m_owner = own; m_last = own; m_grant = own;
          m_addr   = own ? d_addr : i_addr;
          m_we     = own && d_we;
          m_wdata  = own ? d_wdata : 32'h0;
          t_issue  = k + 1;
          d        = (force_d >= 0) ? force_d : int'($urandom_range(0, TO + 1));
          m_data   = (force_d >= 0) ? dir_data : $urandom;
          force_d  = -1;
          if (d < TO) begin m_to = 1'b0; t_ack = k + 3 + d;  end
          else        begin m_to = 1'b1; t_ack = k + 2 + TO; end
        end
      end else if (k == t_ack) begin
        m_active = 1'b0;
      end else if (k + 1 == t_ack) begin
        if (m_to) begin
          if (m_owner) m_drdata = 32'h0; else m_irdata = 32'h0;
        end else if (!m_we) begin
          if (m_owner) m_drdata = m_data; else m_irdata = m_data;
        end
      end
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
`default_nettype wire
